// File: rtl/mem_access_unit.sv
// MEM-stage data memory access unit: issues one load/store at a time on a
// ready-handshake bus, stalls upstream while busy and produces the writeback.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_data,
    input  logic [4:0]  mem_rd_addr,
    input  logic        mem_reg_write,
    input  logic        mem_mem_read,
    input  logic        mem_mem_write,
    input  logic [2:0]  mem_funct3,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd_addr,
    output logic [31:0] wb_result,
    output logic        misaligned
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, state_next;
    logic [1:0]  off;
    logic        aligned, mem_access, mem_op, misaligned_op;
    logic [3:0]  wstrb_next;
    logic [31:0] wdata_next;
    logic [4:0]  lat_rd;
    logic        lat_reg_write;
    logic [2:0]  lat_funct3;
    logic [1:0]  lat_off;
    logic [31:0] rdata_shifted;
    logic [31:0] load_data;

    assign off           = mem_alu_result[1:0];
    assign mem_access    = mem_valid & (mem_mem_read | mem_mem_write);
    assign mem_op        = mem_access & aligned;
    assign misaligned_op = mem_access & ~aligned;

    always_comb begin
        aligned = 1'b0;
        case (mem_funct3)
            3'b000, 3'b100: aligned = 1'b1;
            3'b001, 3'b101: aligned = ~off[0];
            default:        aligned = (off == 2'b00);
        endcase
    end

    // Stores use funct3[1:0] as the size; read wins over write, so loads get no lanes.
    always_comb begin
        wstrb_next = 4'b1111;
        wdata_next = mem_data;
        case (mem_funct3[1:0])
            2'b00: begin
                wstrb_next = 4'b0001 << off;
                wdata_next = {4{mem_data[7:0]}};
            end
            2'b01: begin
                wstrb_next = 4'b0011 << off;
                wdata_next = {2{mem_data[15:0]}};
            end
            default: begin
                wstrb_next = 4'b1111;
                wdata_next = mem_data;
            end
        endcase
        if (mem_mem_read) begin
            wstrb_next = 4'b0000;
            wdata_next = 32'h0;
        end
    end

    assign rdata_shifted = dmem_rdata >> {lat_off, 3'b000};

    always_comb begin
        load_data = dmem_rdata;
        case (lat_funct3)
            3'b000:  load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b001:  load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b100:  load_data = {24'h0, rdata_shifted[7:0]};
            3'b101:  load_data = {16'h0, rdata_shifted[15:0]};
            default: load_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        mem_stall  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    state_next = BUSY;
                    mem_stall  = 1'b1;
                end
            end
            BUSY: begin
                if (dmem_ready) state_next = IDLE;
                else            mem_stall  = 1'b1;
            end
            default: state_next = IDLE;
        endcase
        // Inputs may look like a memory op during reset; never stall then.
        if (rst) mem_stall = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= 32'h0;
            dmem_wdata    <= 32'h0;
            dmem_wstrb    <= 4'h0;
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_rd_addr    <= 5'h0;
            wb_result     <= 32'h0;
            misaligned    <= 1'b0;
            lat_rd        <= 5'h0;
            lat_reg_write <= 1'b0;
            lat_funct3    <= 3'h0;
            lat_off       <= 2'h0;
        end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            misaligned   <= 1'b0;
            if (state == IDLE) begin
                if (mem_op) begin
                    dmem_req      <= 1'b1;
                    dmem_we       <= ~mem_mem_read;
                    dmem_addr     <= {mem_alu_result[31:2], 2'b00};
                    dmem_wstrb    <= wstrb_next;
                    dmem_wdata    <= wdata_next;
                    lat_rd        <= mem_rd_addr;
                    lat_reg_write <= mem_reg_write;
                    lat_funct3    <= mem_funct3;
                    lat_off       <= off;
                end else if (misaligned_op) begin
                    wb_valid   <= 1'b1;
                    misaligned <= 1'b1;
                    wb_rd_addr <= mem_rd_addr;
                    wb_result  <= mem_alu_result;
                end else if (mem_valid) begin
                    wb_valid     <= 1'b1;
                    wb_reg_write <= mem_reg_write;
                    wb_rd_addr   <= mem_rd_addr;
                    wb_result    <= mem_alu_result;
                end
            end else if (dmem_ready) begin
                dmem_req     <= 1'b0;
                wb_valid     <= 1'b1;
                wb_reg_write <= lat_reg_write & ~dmem_we;
                wb_rd_addr   <= lat_rd;
                wb_result    <= dmem_we ? 32'h0 : load_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, misaligned accesses,
// pipeline back-to-back flow and reset during a pending transaction.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_data;
    logic [4:0]  mem_rd_addr;
    logic        mem_reg_write;
    logic        mem_mem_read;
    logic        mem_mem_write;
    logic [2:0]  mem_funct3;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_result;
    logic        misaligned;

    int errors = 0;
    int checks = 0;

    mem_access_unit dut (
        .clk            (clk),
        .rst            (rst),
        .mem_valid      (mem_valid),
        .mem_alu_result (mem_alu_result),
        .mem_data       (mem_data),
        .mem_rd_addr    (mem_rd_addr),
        .mem_reg_write  (mem_reg_write),
        .mem_mem_read   (mem_mem_read),
        .mem_mem_write  (mem_mem_write),
        .mem_funct3     (mem_funct3),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_wstrb     (dmem_wstrb),
        .dmem_ready     (dmem_ready),
        .dmem_rdata     (dmem_rdata),
        .mem_stall      (mem_stall),
        .wb_valid       (wb_valid),
        .wb_reg_write   (wb_reg_write),
        .wb_rd_addr     (wb_rd_addr),
        .wb_result      (wb_result),
        .misaligned     (misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic valid, input logic [31:0] alu, input logic [31:0] data,
                         input logic [4:0] rd, input logic rw, input logic rd_en,
                         input logic wr_en, input logic [2:0] f3);
        mem_valid      = valid;
        mem_alu_result = alu;
        mem_data       = data;
        mem_rd_addr    = rd;
        mem_reg_write  = rw;
        mem_mem_read   = rd_en;
        mem_mem_write  = wr_en;
        mem_funct3     = f3;
    endtask

    // Instruction already driven; walks accept, wait and completion cycles.
    task automatic run_access(input string tag, input int waits, input logic [31:0] rdata,
                              input logic [31:0] exp_addr, input logic exp_we,
                              input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata);
        #1 chk({tag, " stall_accept"}, mem_stall, 1);
        tick();
        chk({tag, " req"}, dmem_req, 1);
        chk({tag, " addr"}, dmem_addr, exp_addr);
        chk({tag, " we"}, dmem_we, exp_we);
        chk({tag, " wstrb"}, dmem_wstrb, exp_wstrb);
        chk({tag, " wdata"}, dmem_wdata, exp_wdata);
        chk({tag, " wb_bubble"}, wb_valid, 0);
        for (int i = 0; i < waits; i++) begin
            chk({tag, " stall_wait"}, mem_stall, 1);
            chk({tag, " addr_hold"}, dmem_addr, exp_addr);
            tick();
        end
        dmem_ready = 1'b1;
        dmem_rdata = rdata;
        #1;
        chk({tag, " stall_ready"}, mem_stall, 0);
        chk({tag, " req_ready"}, dmem_req, 1);
        chk({tag, " addr_ready"}, dmem_addr, exp_addr);
        tick();
        dmem_ready = 1'b0;
        mem_valid  = 1'b0;
        chk({tag, " req_clear"}, dmem_req, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        drive(1, 32'h100, 0, 5'd1, 1, 1, 0, 3'b010);
        #3;
        chk("rst stall", mem_stall, 0);
        chk("rst req", dmem_req, 0);
        chk("rst wb_valid", wb_valid, 0);
        chk("rst wb_result", wb_result, 0);
        chk("rst misaligned", misaligned, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 3'b000);
        tick();
        rst = 1'b0;
        tick();

        // LW 0x100, 3 wait cycles
        drive(1, 32'h100, 0, 5'd5, 1, 1, 0, 3'b010);
        run_access("lw", 3, 32'hDEADBEEF, 32'h100, 0, 4'b0000, 32'h0);
        chk("lw wb_valid", wb_valid, 1);
        chk("lw wb_result", wb_result, 32'hDEADBEEF);
        chk("lw wb_rd", wb_rd_addr, 5'd5);
        chk("lw wb_rw", wb_reg_write, 1);
        tick();
        chk("lw wb_once", wb_valid, 0);

        drive(1, 32'h103, 0, 5'd6, 1, 1, 0, 3'b000);
        run_access("lb", 0, 32'h80FF_0000, 32'h100, 0, 4'b0000, 32'h0);
        chk("lb result", wb_result, 32'hFFFFFF80);
        drive(1, 32'h103, 0, 5'd6, 1, 1, 0, 3'b100);
        run_access("lbu", 0, 32'h80FF_0000, 32'h100, 0, 4'b0000, 32'h0);
        chk("lbu result", wb_result, 32'h00000080);
        drive(1, 32'h102, 0, 5'd6, 1, 1, 0, 3'b001);
        run_access("lh", 1, 32'h80FF_0000, 32'h100, 0, 4'b0000, 32'h0);
        chk("lh result", wb_result, 32'hFFFF80FF);
        drive(1, 32'h102, 0, 5'd6, 1, 1, 0, 3'b101);
        run_access("lhu", 0, 32'h80FF_0000, 32'h100, 0, 4'b0000, 32'h0);
        chk("lhu result", wb_result, 32'h000080FF);

        // read wins when both read and write are set
        drive(1, 32'h204, 0, 5'd2, 1, 1, 1, 3'b010);
        run_access("rdwr", 0, 32'h0BAD_F00D, 32'h204, 0, 4'b0000, 32'h0);
        chk("rdwr result", wb_result, 32'h0BADF00D);

        // stores (reg_write driven high to check it is dropped)
        drive(1, 32'h102, 32'h1234ABCD, 5'd9, 1, 0, 1, 3'b001);
        run_access("sh", 2, 32'h0, 32'h100, 1, 4'b1100, 32'hABCDABCD);
        chk("sh wb_valid", wb_valid, 1);
        chk("sh wb_rw", wb_reg_write, 0);
        drive(1, 32'h101, 32'h000000A5, 5'd9, 1, 0, 1, 3'b000);
        run_access("sb", 0, 32'h0, 32'h100, 1, 4'b0010, 32'hA5A5A5A5);
        drive(1, 32'h104, 32'hCAFEF00D, 5'd9, 1, 0, 1, 3'b010);
        run_access("sw", 0, 32'h0, 32'h104, 1, 4'b1111, 32'hCAFEF00D);
        chk("sw wb_rw", wb_reg_write, 0);
        tick();

        // misaligned accesses
        drive(1, 32'h101, 0, 5'd4, 1, 1, 0, 3'b010);
        #1 chk("mis_lw stall", mem_stall, 0);
        tick();
        chk("mis_lw req", dmem_req, 0);
        chk("mis_lw flag", misaligned, 1);
        chk("mis_lw wb_valid", wb_valid, 1);
        chk("mis_lw wb_rw", wb_reg_write, 0);
        mem_valid = 1'b0;
        tick();
        chk("mis_lw pulse", misaligned, 0);
        chk("mis_lw req2", dmem_req, 0);
        drive(1, 32'h103, 32'h1, 5'd4, 0, 0, 1, 3'b001);
        tick();
        chk("mis_sh flag", misaligned, 1);
        drive(1, 32'h102, 0, 5'd4, 1, 1, 0, 3'b011);
        tick();
        chk("mis_undef flag", misaligned, 1);
        mem_valid = 1'b0;

        // stray ready in IDLE
        dmem_ready = 1'b1;
        tick();
        chk("idle_ready wb", wb_valid, 0);
        chk("idle_ready req", dmem_req, 0);
        dmem_ready = 1'b0;

        // ADD, LW (immediate ready), ADD
        drive(1, 32'h5, 0, 5'd1, 1, 0, 0, 3'b000);
        tick();
        chk("b2b add1 valid", wb_valid, 1);
        chk("b2b add1 result", wb_result, 32'h5);
        drive(1, 32'h200, 0, 5'd7, 1, 1, 0, 3'b010);
        #1 chk("b2b lw stall", mem_stall, 1);
        tick();
        chk("b2b lw bubble", wb_valid, 0);
        dmem_ready = 1'b1;
        dmem_rdata = 32'h11223344;
        #1 chk("b2b lw stall_rdy", mem_stall, 0);
        tick();
        chk("b2b lw valid", wb_valid, 1);
        chk("b2b lw result", wb_result, 32'h11223344);
        chk("b2b lw rd", wb_rd_addr, 5'd7);
        dmem_ready = 1'b0;
        drive(1, 32'h9, 0, 5'd3, 1, 0, 0, 3'b000);
        tick();
        chk("b2b add2 valid", wb_valid, 1);
        chk("b2b add2 result", wb_result, 32'h9);
        chk("b2b add2 rd", wb_rd_addr, 5'd3);
        mem_valid = 1'b0;
        tick();
        chk("b2b end", wb_valid, 0);

        // reset while BUSY
        drive(1, 32'h300, 0, 5'd8, 1, 1, 0, 3'b010);
        tick();
        chk("rstbusy req", dmem_req, 1);
        rst = 1'b1;
        #1;
        chk("rstbusy req_now", dmem_req, 0);
        chk("rstbusy stall", mem_stall, 0);
        mem_valid = 1'b0;
        tick();
        rst = 1'b0;
        dmem_ready = 1'b1;
        dmem_rdata = 32'h55555555;
        tick();
        chk("rstbusy stray wb", wb_valid, 0);
        chk("rstbusy stray req", dmem_req, 0);
        dmem_ready = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
